// File: rtl/shared_dff_arbiter.sv
// Round-robin write controller for one shared WIDTH-bit register with a q/qbar pair.
// A granted requester is re-checked in LOAD, its word is stored and acked, then one turnaround cycle follows.
module shared_dff_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_i,
   input  logic [N*WIDTH-1:0]   d_in_i,
   output logic [N-1:0]         grant_o,
   output logic [N-1:0]         ack_o,
   output logic [WIDTH-1:0]     q_o,
   output logic [WIDTH-1:0]     qbar_o,
   output logic [$clog2(N)-1:0] owner_o,
   output logic                 q_valid_o,
   output logic                 busy_o
);
   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [N-1:0]     ack_q, ack_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    last_q, last_d;
   logic [IW-1:0]    sel_q, sel_d;
   logic             q_valid_q, q_valid_d;

   logic             win_found;
   logic [IW-1:0]    win_idx;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] d_slice [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_slice
         assign d_slice[gi] = d_in_i[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Search starts just after the last successful writer and wraps around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(last_q) + k) % N);
         if (!win_found && req_i[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = '0;
      ack_d     = '0;
      q_d       = q_q;
      owner_d   = owner_q;
      last_d    = last_q;
      sel_d     = sel_q;
      q_valid_d = q_valid_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d[win_idx] = 1'b1;
               sel_d            = win_idx;
               state_d          = LOAD;
            end
         end
         LOAD: begin
            // A requester that let go of req before the load edge forfeits its turn.
            if (req_i[sel_q]) begin
               q_d          = d_slice[sel_q];
               ack_d[sel_q] = 1'b1;
               owner_d      = sel_q;
               last_d       = sel_q;
               q_valid_d    = 1'b1;
               state_d      = DONE;
            end else begin
               state_d = IDLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         ack_q     <= '0;
         q_q       <= '0;
         owner_q   <= '0;
         last_q    <= IW'(N - 1);
         sel_q     <= '0;
         q_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         q_q       <= q_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         sel_q     <= sel_d;
         q_valid_q <= q_valid_d;
      end
   end

   assign grant_o   = grant_q;
   assign ack_o     = ack_q;
   assign q_o       = q_q;
   assign qbar_o    = ~q_q;
   assign owner_o   = owner_q;
   assign q_valid_o = q_valid_q;
   assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_shared_dff_arbiter.sv
// Bench for shared_dff_arbiter: transaction-level round-robin model feeds queues,
// a free-running monitor compares every cycle's outputs against them.
`timescale 1ns/1ps
module tb_shared_dff_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = $clog2(N);

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req = '0;
   logic [W-1:0]   dat [N];
   logic [N*W-1:0] din;
   logic [N-1:0]   grant_o, ack_o;
   logic [W-1:0]   q_o, qbar_o;
   logic [IW-1:0]  owner_o;
   logic           q_valid_o, busy_o;

   shared_dff_arbiter #(.N(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req),
      .d_in_i    (din),
      .grant_o   (grant_o),
      .ack_o     (ack_o),
      .q_o       (q_o),
      .qbar_o    (qbar_o),
      .owner_o   (owner_o),
      .q_valid_o (q_valid_o),
      .busy_o    (busy_o)
   );

   always #5 clk = ~clk;

   always_comb begin
      din = '0;
      for (int i = 0; i < N; i++) din[i*W +: W] = dat[i];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           cyc;
      int           w;
      logic [W-1:0] data;
   } exp_t;

   exp_t gq[$];
   exp_t aq[$];
   bit   busy_exp[int];

   int checks = 0;
   int errors = 0;

   int last_m  = N - 1;
   int free_at = 0;
   int drop_edge [N];
   int abort_mode = 0;
   bit hold_mode = 0;
   int n_pred = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   // Called at a negedge after the caller has set up req/dat for the coming edge.
   task automatic tick();
      int   e;
      int   w;
      bit   ab;
      exp_t x;
      e = cyc + 1;
      for (int i = 0; i < N; i++) begin
         if (drop_edge[i] == e) begin
            req[i]       = 1'b0;
            drop_edge[i] = -1;
         end
      end
      if (rst_n && e >= free_at && req != '0) begin
         w  = rr_pick(req, last_m);
         ab = (abort_mode == 1) || (abort_mode == 2 && $urandom_range(7) == 0);
         x.cyc  = e;
         x.w    = w;
         x.data = dat[w];
         gq.push_back(x);
         busy_exp[e] = 1'b1;
         n_pred++;
         if (ab) begin
            drop_edge[w] = e + 1;
            free_at      = e + 2;
         end else begin
            x.cyc = e + 1;
            aq.push_back(x);
            busy_exp[e+1] = 1'b1;
            last_m        = w;
            free_at       = e + 3;
            if (!hold_mode) drop_edge[w] = e + 2;
         end
      end
      @(negedge clk);
   endtask

   task automatic apply_reset(input bit check_now);
      rst_n = 1'b0;
      gq.delete();
      aq.delete();
      busy_exp.delete();
      for (int i = 0; i < N; i++) drop_edge[i] = -1;
      last_m  = N - 1;
      free_at = 0;
      #1;
      if (check_now) begin
         chk("midrst_grant", grant_o, '0);
         chk("midrst_q", q_o, '0);
         chk("midrst_qbar", qbar_o, 8'hFF);
         chk("midrst_busy", busy_o, 1'b0);
         chk("midrst_qvalid", q_valid_o, 1'b0);
      end
      @(negedge clk);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: pops expectations whose cycle has come and checks every output.
   initial begin
      exp_t          x;
      logic [N-1:0]  eg, ea;
      logic [W-1:0]  eq, eqb;
      logic [IW-1:0] eo;
      logic          ev, eb;
      eq = '0;
      eo = '0;
      ev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         eg = '0;
         ea = '0;
         eb = 1'b0;
         if (!rst_n) begin
            eq = '0;
            eo = '0;
            ev = 1'b0;
         end else begin
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
               x = gq.pop_front();
               eg[x.w] = 1'b1;
            end
            if (aq.size() > 0 && aq[0].cyc == cyc) begin
               x = aq.pop_front();
               ea[x.w] = 1'b1;
               eq = x.data;
               eo = IW'(x.w);
               ev = 1'b1;
            end
            eb = busy_exp.exists(cyc);
         end
         eqb = ~eq;
         chk("grant", grant_o, eg);
         chk("ack", ack_o, ea);
         chk("q", q_o, eq);
         chk("qbar", qbar_o, eqb);
         chk("owner", owner_o, eo);
         chk("q_valid", q_valid_o, ev);
         chk("busy", busy_o, eb);
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         drop_edge[i] = -1;
         dat[i]       = '0;
      end
      #1 rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         req = N'($urandom);
         for (int i = 0; i < N; i++) dat[i] = W'($urandom);
         #1;
         chk("rst_q", q_o, '0);
         chk("rst_qbar", qbar_o, 8'hFF);
         chk("rst_grant", grant_o, '0);
         chk("rst_busy", busy_o, 1'b0);
      end
      @(negedge clk);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();

      // Single write from requester 1
      dat[1] = 8'hA5;
      req    = 4'b0010;
      repeat (4) tick();
      chk("single_q", q_o, 8'hA5);
      chk("single_owner", owner_o, 1);

      // Full contention with all requests held from a fresh reset
      apply_reset(0);
      dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
      hold_mode = 1'b1;
      req    = 4'b1111;
      n_pred = 0;
      while (n_pred < 5) tick();
      tick();
      req       = '0;
      hold_mode = 1'b0;
      repeat (3) tick();
      chk("contention_q", q_o, 8'h11);

      // Wrap: last writer 2, then 3,0,1 compete
      apply_reset(0);
      dat[2] = 8'h5C;
      req    = 4'b0100;
      repeat (4) tick();
      dat[0] = 8'h70; dat[1] = 8'h71; dat[3] = 8'h73;
      hold_mode = 1'b1;
      req    = 4'b1011;
      n_pred = 0;
      while (n_pred < 3) tick();
      tick();
      req       = '0;
      hold_mode = 1'b0;
      repeat (3) tick();
      chk("wrap_owner", owner_o, 1);

      // Abort: requester 0 drops in LOAD; last stays 1 so 0 wins over 1 next
      dat[0]     = 8'hE1;
      req        = 4'b0001;
      abort_mode = 1;
      tick();
      abort_mode = 0;
      tick();
      dat[0] = 8'h3C;
      dat[1] = 8'hC3;
      req    = 4'b0011;
      repeat (8) tick();
      chk("abort_owner", owner_o, 1);

      // Reset in the middle of LOAD
      dat[3] = 8'h99;
      req    = 4'b1000;
      tick();
      apply_reset(1);
      repeat (3) tick();

      // Random traffic with occasional aborts
      abort_mode = 2;
      repeat (400) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i]) begin
               dat[i] = W'($urandom);
               if ($urandom_range(2) == 0) req[i] = 1'b1;
            end
         end
         tick();
      end
      abort_mode = 0;
      repeat (24) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
